vrf_lut_requester: RTL and testbench

Read initiator for the lane's parallel-LUT operand path. It takes a command naming a base VRF row and a row count, then issues full-width reads with all `NrBanks` banks requested in the same cycle, which is the condition that routes read data onto the VRF's LUT output instead of the operand crossbar. It collects the returned rows into a small credit-protected buffer and presents them as a ready/valid stream to the LUT unit. It sits between the lane sequencer/LUT unit and the VRF bank request ports.

---
 rtl/vrf_lut_requester.sv | 204 ++++++++++++++++++++
 tb/tb_vrf_lut_requester.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_lut_requester.sv
// vrf_lut_requester
// Full-row read initiator for the parallel-LUT operand path. Every read asserts
// all bank requests together, so the VRF returns the row on its LUT port rather
// than through the operand crossbar. Returned rows land in a small buffer whose
// slots are reserved before each read is issued, and leave as a ready/valid
// stream towards the LUT unit.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a command; cmd_ready_o high
// ST_ISSUE | issuing one full-row read per cycle while banks/credit allow
// ST_DRAIN | final row issued; waiting for its response before done_o

module vrf_lut_requester #(
   parameter int unsigned NrBanks     = 8,
   parameter int unsigned VAddrWidth  = 16,
   parameter int unsigned ElenWidth   = 64,
   parameter int unsigned OpqWidth    = 3,
   parameter int unsigned BufDepth    = 2,
   parameter int unsigned RowCntWidth = 16
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 cmd_valid_i,
   output logic                                 cmd_ready_o,
   input  logic [VAddrWidth-1:0]                cmd_addr_i,
   input  logic [RowCntWidth-1:0]               cmd_rows_i,
   input  logic [NrBanks-1:0]                   bank_free_i,
   output logic [NrBanks-1:0]                   req_o,
   output logic [NrBanks-1:0][VAddrWidth-1:0]   addr_o,
   output logic [NrBanks-1:0]                   wen_o,
   output logic [NrBanks-1:0][OpqWidth-1:0]     tgt_opqueue_o,
   input  logic [NrBanks-1:0][ElenWidth-1:0]    operand_lut_i,
   input  logic [NrBanks-1:0]                   operand_lut_valid_i,
   output logic [NrBanks-1:0][ElenWidth-1:0]    row_data_o,
   output logic                                 row_last_o,
   output logic                                 row_valid_o,
   input  logic                                 row_ready_i,
   output logic                                 done_o,
   output logic                                 err_o
);

   localparam int unsigned PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
   localparam int unsigned CntW = $clog2(BufDepth + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e                  r_state;
   logic [VAddrWidth-1:0]   r_addr;
   logic [RowCntWidth-1:0]  r_rem;
   logic                    r_inflight;
   logic                    r_last;
   logic                    r_done;
   logic                    r_err;
   logic                    r_rst_guard;

   logic [NrBanks-1:0][ElenWidth-1:0] r_mem_data [BufDepth];
   logic [BufDepth-1:0]               r_mem_last;
   logic [PtrW-1:0]                   r_wptr;
   logic [PtrW-1:0]                   r_rptr;
   logic [CntW-1:0]                   r_count;

   logic                    w_all_free;
   logic                    w_pop;
   logic                    w_push;
   logic                    w_rsp_err;
   logic                    w_credit_ok;
   logic                    w_issue;
   logic [CntW:0]           w_occ;
   logic [CntW:0]           w_cap;

   assign w_all_free = &bank_free_i;
   assign w_pop      = row_valid_o & row_ready_i;

   // A slot freed by this cycle's pop can be re-reserved immediately; this is
   // what sustains one row per cycle with a two-entry buffer.
   assign w_occ       = {1'b0, r_count} + {{CntW{1'b0}}, r_inflight};
   assign w_cap       = (CntW + 1)'(BufDepth) + {{CntW{1'b0}}, w_pop};
   assign w_credit_ok = (w_occ < w_cap);

   assign w_issue = (r_state == ST_ISSUE) & w_all_free & w_credit_ok &
                    (r_rem != '0);

   // The read latency is fixed at one cycle, so an outstanding read must see a
   // complete row now. The first edge after reset may still carry the response
   // to a read from before the reset; that stale response is not an error.
   assign w_push    = r_inflight & (&operand_lut_valid_i);
   assign w_rsp_err = r_inflight ? ~(&operand_lut_valid_i)
                                 : ((|operand_lut_valid_i) & ~r_rst_guard);

   assign req_o         = {NrBanks{w_issue}};
   assign wen_o         = '0;
   assign tgt_opqueue_o = '0;
   assign cmd_ready_o   = (r_state == ST_IDLE);
   assign done_o        = r_done;
   assign err_o         = r_err;

   // Broadcast the current row address to every bank.
   always_comb begin
      addr_o = '0;
      for (int b = 0; b < NrBanks; b++) begin
         addr_o[b] = r_addr;
      end
   end

   // Command sequencing, read issue bookkeeping and error/done flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_rem       <= '0;
         r_inflight  <= 1'b0;
         r_last      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_rst_guard <= 1'b1;
      end else begin
         r_done      <= 1'b0;
         r_rst_guard <= 1'b0;
         r_inflight  <= w_issue;
         if (w_rsp_err) begin
            r_err <= 1'b1;
         end
         unique case (r_state)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  r_addr <= cmd_addr_i;
                  r_rem  <= cmd_rows_i;
                  if (cmd_rows_i == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (w_issue) begin
                  r_addr <= r_addr + VAddrWidth'(1);
                  r_rem  <= r_rem - RowCntWidth'(1);
                  r_last <= (r_rem == RowCntWidth'(1));
                  if (r_rem == RowCntWidth'(1)) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // An outstanding read always resolves this cycle (pushed or
               // flagged); with none outstanding, wait out any stray valid.
               if (r_inflight || !(|operand_lut_valid_i)) begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Row buffer: circular storage; push and pop may coincide even when full.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < BufDepth; i++) begin
            r_mem_data[i] <= '0;
         end
         r_mem_last <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
      end else begin
         if (w_push) begin
            r_mem_data[r_wptr] <= operand_lut_i;
            r_mem_last[r_wptr] <= r_last;
            if (r_wptr == PtrW'(BufDepth - 1)) begin
               r_wptr <= '0;
            end else begin
               r_wptr <= r_wptr + PtrW'(1);
            end
         end
         if (w_pop) begin
            if (r_rptr == PtrW'(BufDepth - 1)) begin
               r_rptr <= '0;
            end else begin
               r_rptr <= r_rptr + PtrW'(1);
            end
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign row_valid_o = (r_count != '0);
   assign row_data_o  = r_mem_data[r_rptr];
   assign row_last_o  = r_mem_last[r_rptr] & row_valid_o;

endmodule

// File: tb/tb_vrf_lut_requester.sv
// Bench for vrf_lut_requester: VRF bank model with one-cycle read latency,
// queue-based reference of the expected address and row streams, a per-cycle
// compare process, and directed scenarios with literal expectations.

module tb_vrf_lut_requester;

   localparam int NB = 8;
   localparam int AW = 16;
   localparam int EW = 64;
   localparam int OW = 3;
   localparam int BD = 2;
   localparam int RW = 16;

   logic                     clk_i;
   logic                     rst_ni;
   logic                     cmd_valid_i;
   logic                     cmd_ready_o;
   logic [AW-1:0]            cmd_addr_i;
   logic [RW-1:0]            cmd_rows_i;
   logic [NB-1:0]            bank_free_i;
   logic [NB-1:0]            req_o;
   logic [NB-1:0][AW-1:0]    addr_o;
   logic [NB-1:0]            wen_o;
   logic [NB-1:0][OW-1:0]    tgt_opqueue_o;
   logic [NB-1:0][EW-1:0]    operand_lut_i;
   logic [NB-1:0]            operand_lut_valid_i;
   logic [NB-1:0][EW-1:0]    row_data_o;
   logic                     row_last_o;
   logic                     row_valid_o;
   logic                     row_ready_i;
   logic                     done_o;
   logic                     err_o;

   vrf_lut_requester #(
      .NrBanks(NB), .VAddrWidth(AW), .ElenWidth(EW), .OpqWidth(OW),
      .BufDepth(BD), .RowCntWidth(RW)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_addr_i(cmd_addr_i), .cmd_rows_i(cmd_rows_i),
      .bank_free_i(bank_free_i), .req_o(req_o), .addr_o(addr_o),
      .wen_o(wen_o), .tgt_opqueue_o(tgt_opqueue_o),
      .operand_lut_i(operand_lut_i), .operand_lut_valid_i(operand_lut_valid_i),
      .row_data_o(row_data_o), .row_last_o(row_last_o),
      .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
      .done_o(done_o), .err_o(err_o)
   );

   typedef struct packed {
      logic [NB-1:0][EW-1:0] data;
      logic                  last;
   } row_t;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   int            n_issued, n_popped, n_dropped, n_cmd_issued;
   int            accept_cyc, done_at;
   logic          err_model;
   bit            in_rst;
   logic [NB-1:0] inj_mask;
   bit            hold_prev;
   logic [NB-1:0][EW-1:0] prev_data;
   logic          prev_last;

   logic [AW-1:0] exp_addr_q[$];
   row_t          exp_row_q[$];
   int            issue_cyc_q[$];
   logic [AW-1:0] issue_addr_q[$];
   int            pop_cyc_q[$];
   logic [EW-1:0] pop_b3_q[$];
   logic          pop_last_q[$];

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [EW-1:0] vrf_word(input logic [AW-1:0] a, input int b);
      return {16'hC0DE, 8'(b), 8'h00, 16'h0000, a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("rst_req", 64'(req_o), 64'd0);
      chk("rst_addr", 64'(addr_o == '0), 64'd1);
      chk("rst_row_valid", 64'(row_valid_o), 64'd0);
      chk("rst_row_last", 64'(row_last_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_wen", 64'(wen_o), 64'd0);
      chk("rst_tgt", 64'(tgt_opqueue_o == '0), 64'd1);
   endtask

   // VRF bank model: a full-row request seen in cycle t is answered in t+1.
   initial begin : vrf_model
      logic                  pend;
      logic                  last_bad;
      logic [NB-1:0][AW-1:0] pend_a;
      operand_lut_valid_i = '0;
      operand_lut_i       = '0;
      last_bad            = 1'b0;
      forever begin
         @(negedge clk_i);
         pend   = (req_o != '0);
         pend_a = addr_o;
         @(posedge clk_i);
         #1;
         if (last_bad) err_model = 1'b1;
         last_bad = 1'b0;
         if (pend) begin
            for (int b = 0; b < NB; b++) operand_lut_i[b] = vrf_word(pend_a[b], b);
            operand_lut_valid_i = inj_mask;
            if (inj_mask != '1) begin
               last_bad = 1'b1;
               n_dropped++;
               inj_mask = '1;
            end
         end else begin
            operand_lut_valid_i = '0;
         end
      end
   end

   // Per-cycle compare against the reference queues.
   initial begin : compare
      logic [AW-1:0] ea;
      row_t          er;
      forever begin
         @(negedge clk_i);
         if (!in_rst) begin
            if (req_o != '0) begin
               chk("req_all_ones", 64'(req_o), 64'(8'hFF));
               chk("req_banks_free", 64'(bank_free_i), 64'(8'hFF));
               if (exp_addr_q.size() == 0) begin
                  chk("req_unexpected", 64'(addr_o[0]), 64'hFFFF_FFFF);
               end else begin
                  ea = exp_addr_q.pop_front();
                  for (int b = 0; b < NB; b++) chk("req_addr", 64'(addr_o[b]), 64'(ea));
               end
               n_issued++;
               n_cmd_issued++;
               issue_cyc_q.push_back(cyc);
               issue_addr_q.push_back(addr_o[0]);
            end
            if (row_valid_o && row_ready_i) begin
               if (exp_row_q.size() == 0) begin
                  chk("row_unexpected", 64'(row_data_o[0]), 64'hFFFF_FFFF);
               end else begin
                  er = exp_row_q.pop_front();
                  for (int b = 0; b < NB; b++) chk("row_data", row_data_o[b], er.data[b]);
                  chk("row_last", 64'(row_last_o), 64'(er.last));
               end
               n_popped++;
               pop_cyc_q.push_back(cyc);
               pop_b3_q.push_back(row_data_o[3]);
               pop_last_q.push_back(row_last_o);
            end
            if (hold_prev) begin
               chk("hold_valid", 64'(row_valid_o), 64'd1);
               chk("hold_data", 64'(row_data_o == prev_data), 64'd1);
               chk("hold_last", 64'(row_last_o), 64'(prev_last));
            end
            hold_prev = row_valid_o && !row_ready_i;
            prev_data = row_data_o;
            prev_last = row_last_o;
            chk("credit_bound", 64'((n_issued - n_popped - n_dropped) <= BD), 64'd1);
            chk("err_sticky", 64'(err_o), 64'(err_model));
         end
      end
   end

   task automatic send_cmd(input logic [AW-1:0] a, input int rows, input bit expect_rows);
      logic [AW-1:0] ra;
      row_t          r;
      @(posedge clk_i);
      #1;
      issue_cyc_q.delete();
      issue_addr_q.delete();
      pop_cyc_q.delete();
      pop_b3_q.delete();
      pop_last_q.delete();
      n_cmd_issued = 0;
      for (int i = 0; i < rows; i++) begin
         ra = a + AW'(i);
         exp_addr_q.push_back(ra);
         if (expect_rows) begin
            for (int b = 0; b < NB; b++) r.data[b] = vrf_word(ra, b);
            r.last = (i == rows - 1);
            exp_row_q.push_back(r);
         end
      end
      cmd_valid_i = 1'b1;
      cmd_addr_i  = a;
      cmd_rows_i  = RW'(rows);
      @(negedge clk_i);
      chk("cmd_ready_at_accept", 64'(cmd_ready_o), 64'd1);
      accept_cyc = cyc;
      @(posedge clk_i);
      #1;
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit got;
      got = 1'b0;
      for (int k = 0; k < budget && !got; k++) begin
         @(negedge clk_i);
         if (done_o) begin
            got     = 1'b1;
            done_at = cyc;
         end
      end
      if (!got) chk("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_issued(input int n, input int budget);
      bit got;
      got = 1'b0;
      for (int k = 0; k < budget && !got; k++) begin
         @(negedge clk_i);
         #1;
         if (n_cmd_issued >= n) got = 1'b1;
      end
      if (!got) chk("issue_timeout", 64'(n_cmd_issued), 64'(n));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int nb;
      rst_ni      = 1'b0;
      in_rst      = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_addr_i  = '0;
      cmd_rows_i  = '0;
      bank_free_i = '1;
      row_ready_i = 1'b1;
      inj_mask    = '1;
      err_model   = 1'b0;
      hold_prev   = 1'b0;
      n_issued = 0; n_popped = 0; n_dropped = 0; n_cmd_issued = 0;
      repeat (2) @(negedge clk_i);
      chk_reset_vals();
      #1 rst_ni = 1'b1;
      in_rst = 1'b0;
      repeat (2) @(negedge clk_i);

      // 4 rows from 0x10, back-to-back
      send_cmd(16'h0010, 4, 1'b1);
      wait_done(30);
      repeat (3) @(negedge clk_i);
      chk("t1_n_issued", 64'(n_cmd_issued), 64'd4);
      for (int i = 0; i < 4; i++) chk("t1_addr", 64'(issue_addr_q[i]), 64'(16'h0010 + i));
      chk("t1_first_req_lat", 64'(issue_cyc_q[0] - accept_cyc), 64'd1);
      chk("t1_consecutive", 64'(issue_cyc_q[3] - issue_cyc_q[0]), 64'd3);
      chk("t1_done_lat", 64'(done_at - issue_cyc_q[3]), 64'd2);
      chk("t1_n_pops", 64'(pop_cyc_q.size()), 64'd4);
      chk("t1_first_row_lat", 64'(pop_cyc_q[0] - accept_cyc), 64'd3);
      chk("t1_row0_b3", pop_b3_q[0], 64'hC0DE_0300_0000_0010);
      chk("t1_row3_b3", pop_b3_q[3], 64'hC0DE_0300_0000_0013);
      for (int i = 0; i < 4; i++) chk("t1_last_flag", 64'(pop_last_q[i]), 64'(i == 3));

      // zero-row command
      send_cmd(16'h0020, 0, 1'b1);
      wait_done(5);
      chk("t2_done_lat", 64'(done_at - accept_cyc), 64'd1);
      chk("t2_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("t2_no_req", 64'(n_cmd_issued), 64'd0);

      // back-pressure: 5 rows with the consumer stalled
      row_ready_i = 1'b0;
      send_cmd(16'h0040, 5, 1'b1);
      repeat (8) @(negedge clk_i);
      chk("t3_stalled_issues", 64'(n_cmd_issued), 64'd2);
      chk("t3_buffered_valid", 64'(row_valid_o), 64'd1);
      @(posedge clk_i);
      #1 row_ready_i = 1'b1;
      wait_done(40);
      repeat (3) @(negedge clk_i);
      chk("t3_n_issued", 64'(n_cmd_issued), 64'd5);
      chk("t3_n_pops", 64'(pop_cyc_q.size()), 64'd5);
      chk("t3_model_empty", 64'(exp_row_q.size()), 64'd0);

      // one bank claimed by a writer for 3 cycles mid-command
      send_cmd(16'h0080, 6, 1'b1);
      wait_issued(2, 20);
      @(posedge clk_i);
      #1 bank_free_i = 8'hFE;
      nb = n_cmd_issued;
      repeat (3) @(posedge clk_i);
      #1 bank_free_i = '1;
      chk("t4_blocked_no_req", 64'(n_cmd_issued), 64'(nb));
      wait_done(40);
      repeat (3) @(negedge clk_i);
      chk("t4_n_issued", 64'(n_cmd_issued), 64'd6);
      for (int i = 0; i < 6; i++) chk("t4_addr", 64'(issue_addr_q[i]), 64'(16'h0080 + i));
      chk("t4_gap", 64'(issue_cyc_q[2] - issue_cyc_q[1]), 64'd4);
      chk("t4_n_pops", 64'(pop_cyc_q.size()), 64'd6);

      // address wrap
      send_cmd(16'hFFFF, 2, 1'b1);
      wait_done(20);
      repeat (2) @(negedge clk_i);
      chk("t5_addr0", 64'(issue_addr_q[0]), 64'h0000_0000_0000_FFFF);
      chk("t5_addr1", 64'(issue_addr_q[1]), 64'h0);
      chk("t5_n_pops", 64'(pop_cyc_q.size()), 64'd2);

      // partial valid on the response
      inj_mask = 8'h7F;
      send_cmd(16'h0030, 1, 1'b0);
      wait_done(20);
      repeat (2) @(negedge clk_i);
      chk("t6_err", 64'(err_o), 64'd1);
      chk("t6_no_row", 64'(pop_cyc_q.size()), 64'd0);
      chk("t6_row_valid", 64'(row_valid_o), 64'd0);

      // reset with one row buffered and one read outstanding
      row_ready_i = 1'b0;
      send_cmd(16'h0050, 3, 1'b1);
      wait_issued(2, 20);
      @(negedge clk_i);
      #1;
      chk("t7_buffered_before_rst", 64'(row_valid_o), 64'd1);
      in_rst = 1'b1;
      rst_ni = 1'b0;
      #1;
      chk_reset_vals();
      #1 rst_ni = 1'b1;
      exp_addr_q.delete();
      exp_row_q.delete();
      n_issued = 0; n_popped = 0; n_dropped = 0;
      err_model = 1'b0;
      hold_prev = 1'b0;
      in_rst    = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("t7_err_after_rst", 64'(err_o), 64'd0);
      chk("t7_valid_after_rst", 64'(row_valid_o), 64'd0);
      @(posedge clk_i);
      #1 row_ready_i = 1'b1;
      send_cmd(16'h0060, 1, 1'b1);
      wait_done(20);
      repeat (2) @(negedge clk_i);
      chk("t7_n_issued", 64'(n_cmd_issued), 64'd1);
      chk("t7_addr", 64'(issue_addr_q[0]), 64'h60);
      chk("t7_n_pops", 64'(pop_cyc_q.size()), 64'd1);
      chk("t7_last", 64'(pop_last_q[0]), 64'd1);
      chk("t7_model_empty", 64'(exp_row_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
